// File: rtl/fir_mac.sv
// fir_mac: single-MAC FIR engine fed by an external coefficient ROM.
// One accepted sample starts one pass over FIR_TAP taps; each pass yields one
// rounded output sample after FIR_TAP+3 cycles.
// Build option: define FIR_MAC_SAT_EN to saturate the output to DATA_WIDTH;
// otherwise the rounded result wraps to its low DATA_WIDTH bits.
module fir_mac #(
  parameter int FIR_TAP       = 128,
  parameter int FIR_TAP_WIDTH = 16,
  parameter int FIR_TAP_ADDR  = 7,
  parameter int DATA_WIDTH    = 16,
  parameter int ACC_WIDTH     = 40,
  parameter int OUT_SHIFT     = 15
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            in_valid,
  input  logic signed [DATA_WIDTH-1:0]    in_data,
  output logic                            in_ready,
  output logic        [FIR_TAP_ADDR-1:0]  coeff_addr,
  input  logic signed [FIR_TAP_WIDTH-1:0] coeff_data,
  output logic                            out_valid,
  output logic signed [DATA_WIDTH-1:0]    out_data,
  output logic                            busy
);

  localparam int PROD_W = DATA_WIDTH + FIR_TAP_WIDTH;
  localparam int FILL_W = FIR_TAP_ADDR + 1;

  localparam logic [FIR_TAP_ADDR-1:0] LAST_K   = FIR_TAP_ADDR'(FIR_TAP - 1);
  localparam logic [FILL_W-1:0]       FILL_MAX = FILL_W'(FIR_TAP);

  // Rounding bias: half an output LSB in accumulator units.
  localparam logic signed [ACC_WIDTH-1:0] RND_BIAS =
    {{(ACC_WIDTH-1){1'b0}}, 1'b1} << (OUT_SHIFT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state_r, state_nxt_s;

  logic [FIR_TAP_ADDR-1:0] wr_ptr_r;
  logic [FIR_TAP_ADDR-1:0] newest_r;
  logic [FILL_W-1:0]       fill_r;
  logic [FIR_TAP_ADDR-1:0] k_r;

  // History RAM is never cleared; fill_r masks entries not yet written.
  logic signed [DATA_WIDTH-1:0] hist_mem [0:FIR_TAP-1];
  logic signed [DATA_WIDTH-1:0] hist_q_r;

  // Stage 2: ROM data and history sample are aligned in this stage.
  logic v2_r, first2_r, last2_r, mask2_r;
  // Stage 3: registered product.
  logic signed [PROD_W-1:0] prod_r;
  logic v3_r, first3_r, last3_r;

  logic signed [DATA_WIDTH-1:0] samp_s;
  logic signed [ACC_WIDTH-1:0]  acc_r;
  logic signed [ACC_WIDTH-1:0]  acc_sum_s;
  logic signed [DATA_WIDTH-1:0] out_data_r;
  logic                         out_valid_r;
  logic                         accept_s;

  // Round the accumulator and bring it back to the output width.
  function automatic logic signed [DATA_WIDTH-1:0] round_reduce(
    input logic signed [ACC_WIDTH-1:0] a
  );
`ifdef FIR_MAC_SAT_EN
    logic signed [ACC_WIDTH-1:0] shifted;
    logic signed [ACC_WIDTH-1:0] sat_max;
    logic signed [ACC_WIDTH-1:0] sat_min;
    shifted = (a + RND_BIAS) >>> OUT_SHIFT;
    sat_max = ACC_WIDTH'({1'b0, {(DATA_WIDTH-1){1'b1}}});
    sat_min = ~sat_max;
    if (shifted > sat_max) begin
      return sat_max[DATA_WIDTH-1:0];
    end else if (shifted < sat_min) begin
      return sat_min[DATA_WIDTH-1:0];
    end else begin
      return shifted[DATA_WIDTH-1:0];
    end
`else
    return DATA_WIDTH'((a + RND_BIAS) >>> OUT_SHIFT);
`endif
  endfunction

  assign accept_s = in_valid && (state_r == IDLE);

  // Next-state logic for the pass sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (k_r == LAST_K) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DRAIN: begin
        // Leave exactly when the final product lands, so IDLE coincides with out_valid.
        if (v3_r && last3_r) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Masked sample operand and accumulator update value.
  always_comb begin
    samp_s    = {DATA_WIDTH{1'b0}};
    acc_sum_s = {ACC_WIDTH{1'b0}};
    if (mask2_r) begin
      samp_s = {DATA_WIDTH{1'b0}};
    end else begin
      samp_s = hist_q_r;
    end
    if (first3_r) begin
      acc_sum_s = ACC_WIDTH'(prod_r);
    end else begin
      acc_sum_s = acc_r + ACC_WIDTH'(prod_r);
    end
  end

  // History write on accept and registered history read during RUN.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      hist_mem[wr_ptr_r] <= in_data;
    end
    hist_q_r <= hist_mem[newest_r - k_r];
  end

  // Control state, pointers, pipeline and output registers.
  always_ff @(posedge clk) begin
    if (resetn) begin
      state_r     <= IDLE;
      wr_ptr_r    <= {FIR_TAP_ADDR{1'b0}};
      newest_r    <= {FIR_TAP_ADDR{1'b0}};
      fill_r      <= {FILL_W{1'b0}};
      k_r         <= {FIR_TAP_ADDR{1'b0}};
      v2_r        <= 1'b0;
      first2_r    <= 1'b0;
      last2_r     <= 1'b0;
      mask2_r     <= 1'b0;
      prod_r      <= {PROD_W{1'b0}};
      v3_r        <= 1'b0;
      first3_r    <= 1'b0;
      last3_r     <= 1'b0;
      acc_r       <= {ACC_WIDTH{1'b0}};
      out_data_r  <= {DATA_WIDTH{1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;

      if (accept_s) begin
        newest_r <= wr_ptr_r;
        wr_ptr_r <= wr_ptr_r + {{(FIR_TAP_ADDR-1){1'b0}}, 1'b1};
        if (fill_r != FILL_MAX) begin
          fill_r <= fill_r + {{(FILL_W-1){1'b0}}, 1'b1};
        end
      end

      // Tap index runs 0..FIR_TAP-1 in RUN and wraps back to 0 afterwards.
      if (state_r == RUN) begin
        k_r <= k_r + {{(FIR_TAP_ADDR-1){1'b0}}, 1'b1};
      end else begin
        k_r <= {FIR_TAP_ADDR{1'b0}};
      end

      v2_r     <= (state_r == RUN);
      first2_r <= (k_r == {FIR_TAP_ADDR{1'b0}});
      last2_r  <= (k_r == LAST_K);
      mask2_r  <= ({1'b0, k_r} >= fill_r);

      prod_r   <= PROD_W'(samp_s) * PROD_W'(coeff_data);
      v3_r     <= v2_r;
      first3_r <= first2_r;
      last3_r  <= last2_r;

      if (v3_r) begin
        acc_r <= acc_sum_s;
      end

      out_valid_r <= v3_r && last3_r;
      if (v3_r && last3_r) begin
        out_data_r <= round_reduce(acc_sum_s);
      end
    end
  end

  assign in_ready   = (state_r == IDLE);
  assign busy       = (state_r != IDLE);
  assign coeff_addr = k_r;
  assign out_valid  = out_valid_r;
  assign out_data   = out_data_r;

endmodule

// File: tb/tb_fir_mac.sv
// Directed bench for fir_mac with a registered coefficient ROM model.
module tb_fir_mac;
  localparam int N = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                resetn;
  logic                in_valid;
  logic signed [15:0]  in_data;
  logic                in_ready;
  logic [6:0]          coeff_addr;
  logic signed [15:0]  coeff_data;
  logic                out_valid;
  logic signed [15:0]  out_data;
  logic                busy;

  logic signed [15:0]  rom [0:N-1];
  int errors = 0;
  int checks = 0;

  fir_mac dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .coeff_addr (coeff_addr),
    .coeff_data (coeff_data),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .busy       (busy)
  );

  // Synchronous ROM: data one cycle after address.
  always @(posedge clk) coeff_data <= rom[coeff_addr];

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn   = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b0;
  endtask

  task automatic set_rom_const(input logic signed [15:0] v);
    for (int i = 0; i < N; i++) rom[i] = v;
  endtask

  // Send one sample from IDLE and wait (bounded) for its output.
  // hs_bad counts handshake anomalies: in_ready high or busy low mid-pass,
  // or in_ready low / busy high in the strobe cycle.
  task automatic run_sample(input logic signed [15:0] d, output int res,
                            output int lat, output int hs_bad);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = -1; res = 0; hs_bad = 0;
    for (int n = 1; n <= 300 && lat < 0; n++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = n;
        res = out_data;
        if (!in_ready || busy) hs_bad++;
      end else begin
        if (in_ready || !busy) hs_bad++;
      end
    end
  endtask

  initial begin
    int res, lat, hs;
    int acc_cnt, out_cnt, running, ov_cnt;
    int sums [0:7];

    resetn = 1'b1; in_valid = 1'b0; in_data = 16'sd0;
    set_rom_const(16'sh4000);
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_coeff_addr", coeff_addr, 0);
    resetn = 1'b0;

    // First and second samples, all coefficients 0x4000
    run_sample(16'sh4000, res, lat, hs);
    chk("first_out", res, 8192);
    chk("first_latency", lat, 131);
    chk("first_handshake", hs, 0);
    @(negedge clk);
    chk("strobe_one_cycle", out_valid, 0);
    chk("coeff_addr_idle", coeff_addr, 0);
    run_sample(16'sh4000, res, lat, hs);
    chk("second_out", res, 16384);
    chk("second_latency", lat, 131);

    // Impulse response through h[k]=2k, then wrap check
    do_reset();
    for (int i = 0; i < N; i++) rom[i] = 16'(2 * i);
    for (int n = 0; n <= N; n++) begin
      run_sample((n == 0) ? 16'sh4000 : 16'sh0000, res, lat, hs);
      chk($sformatf("impulse_%0d", n), res, (n < N) ? n : 0);
    end

    // Full-scale history and coefficients
    do_reset();
    set_rom_const(16'sh7FFF);
    for (int n = 0; n < N; n++) begin
      run_sample(16'sh7FFF, res, lat, hs);
`ifdef FIR_MAC_SAT_EN
      if (n == 1)     chk("sat_second", res, 32767);
      if (n == N - 1) chk("sat_full", res, 32767);
`else
      if (n == 1)     chk("wrap_second", res, -4);
      if (n == N - 1) chk("wrap_full", res, -256);
`endif
    end

    // in_valid held high with changing data
    do_reset();
    set_rom_const(16'sh4000);
    acc_cnt = 0; out_cnt = 0; running = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (out_valid) begin
        chk($sformatf("held_out_%0d", out_cnt), out_data,
            (out_cnt < 8) ? (sums[out_cnt] + 1) / 2 : -1);
        out_cnt++;
      end
      in_valid = 1'b1;
      in_data  = 16'(100 + i);
      if (in_ready && acc_cnt < 8) begin
        running += 100 + i;
        sums[acc_cnt] = running;
        acc_cnt++;
      end
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int i = 0; i < 300 && out_cnt < acc_cnt; i++) begin
      @(negedge clk);
      if (out_valid) begin
        chk($sformatf("held_out_%0d", out_cnt), out_data,
            (out_cnt < 8) ? (sums[out_cnt] + 1) / 2 : -1);
        out_cnt++;
      end
    end
    chk("held_accepts", acc_cnt, 4);
    chk("held_outputs", out_cnt, acc_cnt);

    // Reset in the middle of a pass
    do_reset();
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'sh4000;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (59) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    resetn = 1'b0;
    ov_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_valid) ov_cnt++;
    end
    chk("abort_no_strobe", ov_cnt, 0);
    chk("abort_busy", busy, 0);
    run_sample(16'sh4000, res, lat, hs);
    chk("abort_next_out", res, 8192);
    chk("abort_next_latency", lat, 131);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
